// File: rtl/riscv_structures.sv
// Shared RISC-V definitions for the load/store unit.
// Holds the funct3 memory-size encodings, the LSU FSM states, and a helper
// that decides whether a funct3 code is a legal access for the given direction
// and register width.
package riscv_structures;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_D  = 3'b011,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101,
    MEM_WU = 3'b110
  } mem_size_e;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_WAIT = 1'b1
  } lsu_state_e;

  // Unsigned variants exist only for loads; doubleword forms need XLEN=64.
  function automatic logic funct3_legal(input logic [2:0] f3, input logic is_load,
                                        input logic xlen64);
    logic ok;
    ok = 1'b0;
    case (f3)
      MEM_B, MEM_H, MEM_W: ok = 1'b1;
      MEM_D:               ok = xlen64;
      MEM_BU, MEM_HU:      ok = is_load;
      MEM_WU:              ok = is_load & xlen64;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction and extension.
// Ports: rdata (full bus word), lane_off (byte offset of the datum within the
// word), size (log2 of access bytes), is_unsigned (zero- instead of
// sign-extend), data (right-aligned, extended result). Purely combinational.
module lsu_load_align #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]              rdata,
  input  logic [$clog2(XLEN/8)-1:0]    lane_off,
  input  logic [1:0]                   size,
  input  logic                         is_unsigned,
  output logic [XLEN-1:0]              data
);

  localparam int IW = $clog2(XLEN);

  logic [XLEN-1:0] shifted;
  logic [IW-1:0]   msb_idx;
  logic            ext;
  int              width;

  always_comb begin
    shifted = rdata >> {lane_off, 3'b000};
    width   = 8 << size;
    if (width > XLEN) width = XLEN;
    msb_idx = IW'(width - 1);
    ext     = ~is_unsigned & shifted[msb_idx];
    data    = '0;
    for (int i = 0; i < XLEN; i++) begin
      data[i] = (i < width) ? shifted[i] : ext;
    end
  end

endmodule

// File: rtl/memory_lsu.sv
// Load/store unit between the execute stage and a single-port data memory.
// Ports: clk/rst; in_* op from execute (held stable while stall is high);
// dmem_* request/response bus; stall back-pressure; wb_* registered result,
// wb_valid pulses one cycle per completed op.
// Build option: LSU_MISALIGN_TRAP_EN adds wb_misalign and turns misaligned
// accesses into traps; otherwise misaligned addresses are forced aligned.
//
// state    | meaning
// LSU_IDLE | accept op; zero-wait or non-memory ops complete here
// LSU_WAIT | request held on the bus, waiting for dmem_ack or timeout
module memory_lsu
  import riscv_structures::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_be,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              stall,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              wb_misalign,
`endif
  output logic              wb_bus_err
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_reg_write_q, wb_reg_write_d;
  logic            wb_bus_err_q, wb_bus_err_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic            wb_misalign_q, wb_misalign_d;
  logic            misaligned;
`endif

  logic            is_load, is_store, mem_op, f3_ok, access_ok;
  logic            req, timeout_hit;
  logic [OW-1:0]   addr_off, size_mask, eff_off, src_lane;
  logic [XLEN-1:0] load_data;

  always_comb begin
    is_load   = in_mem_read;
    is_store  = in_mem_write & ~in_mem_read;
    mem_op    = is_load | is_store;
    f3_ok     = funct3_legal(in_funct3, is_load, XLEN == 64);
    addr_off  = in_addr[OW-1:0];
    size_mask = OW'((1 << in_funct3[1:0]) - 1);
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = |(addr_off & size_mask);
    access_ok  = mem_op & f3_ok & ~misaligned;
    eff_off    = addr_off;
`else
    access_ok  = mem_op & f3_ok;
    eff_off    = addr_off & ~size_mask;
`endif
  end

  // Lane enables cover [eff_off, eff_off + size); store data is replicated by
  // wrapping the lane index within the access size.
  always_comb begin
    dmem_be    = '0;
    dmem_wdata = '0;
    src_lane   = '0;
    for (int i = 0; i < NB; i++) begin
      dmem_be[i] = (i >= int'(eff_off)) && (i <= int'(eff_off) + int'(size_mask));
      src_lane   = OW'(i) & size_mask;
      dmem_wdata[8*i +: 8] = in_wdata[{src_lane, 3'b000} +: 8];
    end
    dmem_addr = {in_addr[XLEN-1:OW], {OW{1'b0}}};
  end

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata       (dmem_rdata),
    .lane_off    (eff_off),
    .size        (in_funct3[1:0]),
    .is_unsigned (in_funct3[2]),
    .data        (load_data)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    req            = 1'b0;
    timeout_hit    = 1'b0;
    wb_valid_d     = 1'b0;
    wb_data_d      = wb_data_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_bus_err_d   = wb_bus_err_q;
`ifdef LSU_MISALIGN_TRAP_EN
    wb_misalign_d  = wb_misalign_q;
`endif
    case (state_q)
      LSU_IDLE: begin
        if (in_valid) begin
          if (access_ok) begin
            req = 1'b1;
            if (dmem_ack) begin
              wb_valid_d     = 1'b1;
              wb_data_d      = is_load ? load_data : in_addr;
              wb_rd_d        = in_rd;
              wb_reg_write_d = in_reg_write;
              wb_bus_err_d   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
              wb_misalign_d  = 1'b0;
`endif
            end else begin
              state_d = LSU_WAIT;
              cnt_d   = CW'(TIMEOUT);
            end
          end else begin
            // Non-memory ops, illegal funct3 and trapped misaligns finish here.
            wb_valid_d     = 1'b1;
            wb_data_d      = in_addr;
            wb_rd_d        = in_rd;
            wb_reg_write_d = mem_op ? 1'b0 : in_reg_write;
            wb_bus_err_d   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            wb_misalign_d  = mem_op & f3_ok & misaligned;
`endif
          end
        end
      end
      LSU_WAIT: begin
        req = 1'b1;
        wb_rd_d = in_rd;
        if (dmem_ack) begin
          state_d        = LSU_IDLE;
          cnt_d          = '0;
          wb_valid_d     = 1'b1;
          wb_data_d      = is_load ? load_data : in_addr;
          wb_reg_write_d = in_reg_write;
          wb_bus_err_d   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
          wb_misalign_d  = 1'b0;
`endif
        end else if (cnt_q <= CW'(1)) begin
          timeout_hit    = 1'b1;
          state_d        = LSU_IDLE;
          cnt_d          = '0;
          wb_valid_d     = 1'b1;
          wb_data_d      = in_addr;
          wb_reg_write_d = 1'b0;
          wb_bus_err_d   = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
          wb_misalign_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // The timeout cycle ends the op, so stall drops there too; otherwise the
  // held op would be reissued from IDLE.
  assign dmem_req = req & ~rst;
  assign dmem_we  = dmem_req & is_store;
  assign stall    = dmem_req & ~dmem_ack & ~timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= LSU_IDLE;
      cnt_q          <= '0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      wb_bus_err_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      wb_misalign_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_bus_err_q   <= wb_bus_err_d;
`ifdef LSU_MISALIGN_TRAP_EN
      wb_misalign_q  <= wb_misalign_d;
`endif
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_bus_err   = wb_bus_err_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign wb_misalign  = wb_misalign_q;
`endif

endmodule

// File: tb/tb_memory_lsu.sv
module tb_memory_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_mem_read, in_mem_write, in_reg_write;
  logic [31:0] in_addr, in_wdata;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall, wb_valid, wb_reg_write, wb_bus_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        wb_misalign;
`endif

  always #5 clk = ~clk;

  memory_lsu #(.XLEN(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_funct3(in_funct3), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
`ifdef LSU_MISALIGN_TRAP_EN
    .wb_misalign(wb_misalign),
`endif
    .wb_bus_err(wb_bus_err)
  );

  typedef struct {
    logic        valid, rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic [4:0]  rdi;
    logic        rw, ack;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_stall, e_wbv;
    logic [31:0] e_wbdata;
    logic        e_rw, e_err, e_mis;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rdi,
                       input logic rw, input logic ack, input logic [31:0] rdata);
    in_valid = v; in_mem_read = rd; in_mem_write = wr; in_funct3 = f3;
    in_addr = addr; in_wdata = wdata; in_rd = rdi; in_reg_write = rw;
    dmem_ack = ack; dmem_rdata = rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int stall_cnt, req_cnt, wbv_cnt, last_req_c;
    logic [31:0] cap_data;
    logic [4:0]  cap_rd;
    logic        cap_rw, cap_err;

    //       vld rd wr f3      addr          wdata          rdi   rw ack rdata
    //       req we e_addr     be    e_wdata        stl wbv wbdata        rw err mis
    v = '{1,0,1,3'b010,32'h100,32'hDEADBEEF,5'd0,0,1,32'h0,
          1,1,32'h100,4'hF,32'hDEADBEEF,0,1,32'h100,0,0,0};            vecs.push_back(v);
    v = '{1,1,0,3'b010,32'h100,32'h0,5'd5,1,1,32'hDEADBEEF,
          1,0,32'h100,4'hF,32'h0,0,1,32'hDEADBEEF,1,0,0};              vecs.push_back(v);
    v = '{1,0,1,3'b000,32'h103,32'h80,5'd0,0,1,32'h0,
          1,1,32'h100,4'h8,32'h80808080,0,1,32'h103,0,0,0};            vecs.push_back(v);
    v = '{1,1,0,3'b000,32'h103,32'h0,5'd6,1,1,32'h80000000,
          1,0,32'h100,4'h8,32'h0,0,1,32'hFFFFFF80,1,0,0};              vecs.push_back(v);
    v = '{1,1,0,3'b100,32'h103,32'h0,5'd6,1,1,32'h80000000,
          1,0,32'h100,4'h8,32'h0,0,1,32'h00000080,1,0,0};              vecs.push_back(v);
    v = '{1,1,0,3'b001,32'h102,32'h0,5'd8,1,1,32'h80010000,
          1,0,32'h100,4'hC,32'h0,0,1,32'hFFFF8001,1,0,0};              vecs.push_back(v);
    v = '{1,1,0,3'b101,32'h102,32'h0,5'd8,1,1,32'h80010000,
          1,0,32'h100,4'hC,32'h0,0,1,32'h00008001,1,0,0};              vecs.push_back(v);
    v = '{1,0,1,3'b001,32'h102,32'h1234ABCD,5'd0,0,1,32'h0,
          1,1,32'h100,4'hC,32'hABCDABCD,0,1,32'h102,0,0,0};            vecs.push_back(v);
    v = '{1,1,0,3'b000,32'h101,32'h0,5'd10,1,1,32'h00007F00,
          1,0,32'h100,4'h2,32'h0,0,1,32'h0000007F,1,0,0};              vecs.push_back(v);
    v = '{1,0,0,3'b010,32'h12345678,32'h0,5'd11,1,0,32'h0,
          0,0,32'h0,4'h0,32'h0,0,1,32'h12345678,1,0,0};                vecs.push_back(v);
    v = '{1,1,0,3'b011,32'h200,32'h0,5'd12,1,0,32'h0,
          0,0,32'h0,4'h0,32'h0,0,1,32'h200,0,0,0};                     vecs.push_back(v);
    v = '{1,1,0,3'b110,32'h204,32'h0,5'd12,1,0,32'h0,
          0,0,32'h0,4'h0,32'h0,0,1,32'h204,0,0,0};                     vecs.push_back(v);
    v = '{1,0,1,3'b100,32'h208,32'h0,5'd0,0,0,32'h0,
          0,0,32'h0,4'h0,32'h0,0,1,32'h208,0,0,0};                     vecs.push_back(v);
    v = '{1,1,1,3'b010,32'h104,32'h55555555,5'd13,1,1,32'hCAFEF00D,
          1,0,32'h104,4'hF,32'h55555555,0,1,32'hCAFEF00D,1,0,0};       vecs.push_back(v);
    v = '{0,0,0,3'b010,32'h0,32'h0,5'd0,0,1,32'h0,
          0,0,32'h0,4'h0,32'h0,0,0,32'h0,0,0,0};                       vecs.push_back(v);
`ifdef LSU_MISALIGN_TRAP_EN
    v = '{1,1,0,3'b010,32'h101,32'h0,5'd14,1,1,32'h11223344,
          0,0,32'h0,4'h0,32'h0,0,1,32'h101,0,0,1};                     vecs.push_back(v);
`else
    v = '{1,1,0,3'b010,32'h101,32'h0,5'd14,1,1,32'h11223344,
          1,0,32'h100,4'hF,32'h0,0,1,32'h11223344,1,0,0};              vecs.push_back(v);
`endif

    // Reset state, with a legal load presented to show the request is gated.
    rst = 1'b1;
    drive(1, 1, 0, 3'b010, 32'h100, 32'h0, 5'd1, 1, 0, 32'h0);
    #12;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_reg_write", wb_reg_write, 0);
    chk("rst_wb_bus_err", wb_bus_err, 0);
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);
    #6 rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      drive(v.valid, v.rd, v.wr, v.f3, v.addr, v.wdata, v.rdi, v.rw, v.ack, v.rdata);
      #3;
      chk($sformatf("v%0d_req", k), dmem_req, v.e_req);
      chk($sformatf("v%0d_we", k), dmem_we, v.e_we);
      chk($sformatf("v%0d_stall", k), stall, v.e_stall);
      if (v.e_req) begin
        chk($sformatf("v%0d_addr", k), dmem_addr, v.e_addr);
        chk($sformatf("v%0d_be", k), dmem_be, v.e_be);
        chk($sformatf("v%0d_wdata", k), dmem_wdata, v.e_wdata);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_wb_valid", k), wb_valid, v.e_wbv);
      if (v.e_wbv) begin
        chk($sformatf("v%0d_wb_data", k), wb_data, v.e_wbdata);
        chk($sformatf("v%0d_wb_reg_write", k), wb_reg_write, v.e_rw);
        chk($sformatf("v%0d_wb_bus_err", k), wb_bus_err, v.e_err);
        chk($sformatf("v%0d_wb_rd", k), wb_rd, v.rdi);
`ifdef LSU_MISALIGN_TRAP_EN
        chk($sformatf("v%0d_wb_misalign", k), wb_misalign, v.e_mis);
`endif
      end
    end
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);
    @(posedge clk); #1;
    chk("pulse_end_wb_valid", wb_valid, 0);

    // LH at 0x102 acknowledged in the fourth request cycle.
    stall_cnt = 0; req_cnt = 0; wbv_cnt = 0; cap_data = '0; cap_rd = '0; cap_rw = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive(c <= 3, 1, 0, 3'b001, 32'h102, 32'h0, 5'd7, 1, c == 3,
            (c == 3) ? 32'hF00D0000 : 32'hFFFFFFFF);
      #3;
      stall_cnt += int'(stall);
      req_cnt   += int'(dmem_req);
      if (wb_valid) begin
        wbv_cnt++; cap_data = wb_data; cap_rd = wb_rd; cap_rw = wb_reg_write;
      end
      @(posedge clk); #1;
    end
    chk("lh_wait_stall_cycles", stall_cnt, 3);
    chk("lh_wait_req_cycles", req_cnt, 4);
    chk("lh_wait_wb_pulses", wbv_cnt, 1);
    chk("lh_wait_wb_data", cap_data, 32'hFFFFF00D);
    chk("lh_wait_wb_rd", cap_rd, 7);
    chk("lh_wait_wb_reg_write", cap_rw, 1);

    // Load that is never acknowledged.
    stall_cnt = 0; req_cnt = 0; wbv_cnt = 0; last_req_c = -1; cap_err = 1'b0; cap_rw = 1'b1;
    for (int c = 0; c < 25; c++) begin
      drive(c <= 15, 1, 0, 3'b010, 32'h300, 32'h0, 5'd9, 1, 0, 32'h0);
      #3;
      stall_cnt += int'(stall);
      req_cnt   += int'(dmem_req);
      if (dmem_req) last_req_c = c;
      if (wb_valid) begin
        wbv_cnt++; cap_err = wb_bus_err; cap_rw = wb_reg_write;
      end
      @(posedge clk); #1;
    end
    chk("timeout_req_cycles", req_cnt, 16);
    chk("timeout_last_req_cycle", last_req_c, 15);
    chk("timeout_stall_cycles", stall_cnt, 15);
    chk("timeout_wb_pulses", wbv_cnt, 1);
    chk("timeout_wb_bus_err", cap_err, 1);
    chk("timeout_wb_reg_write", cap_rw, 0);

    // Reset while waiting, then a normal load.
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 0, 3'b010, 32'h400, 32'h0, 5'd3, 1, 0, 32'h0);
      #3;
      if (c == 2) begin
        chk("rstwait_req_before", dmem_req, 1);
        chk("rstwait_stall_before", stall, 1);
      end
      @(posedge clk); #1;
    end
    #3 rst = 1'b1;
    #1;
    chk("rstwait_req_now", dmem_req, 0);
    chk("rstwait_stall_now", stall, 0);
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);
    @(posedge clk); #4 rst = 1'b0;
    wbv_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #3;
      wbv_cnt += int'(wb_valid);
    end
    chk("rstwait_no_wb_pulse", wbv_cnt, 0);
    @(posedge clk); #1;
    drive(1, 1, 0, 3'b010, 32'h400, 32'h0, 5'd3, 1, 1, 32'hA5A5A5A5);
    #3;
    chk("after_rst_req", dmem_req, 1);
    chk("after_rst_stall", stall, 0);
    @(posedge clk); #1;
    chk("after_rst_wb_valid", wb_valid, 1);
    chk("after_rst_wb_data", wb_data, 32'hA5A5A5A5);
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
